avalon_pio_gen: RTL and testbench
=================================

// Module: avalon_pio_gen
// PURPOSE
//  Parametrised Avalon-MM general-purpose I/O peripheral for the Nios II system; next generation of
//  the fixed 8-bit output-only PIO. Per-bit direction, input synchroniser, edge capture with
//  maskable level interrupt, optional atomic set/clear of output bits. Sits on the CPU data master.
// PARAMETERS
//  WIDTH        8     number of I/O bits, 1..32; readdata bits above WIDTH read 0
//  RESET_VALUE  0     pio_out value after reset (WIDTH bits)
//  EDGE_TYPE    0     capture edge: 0 rising, 1 falling, 2 any
//  SYNC_STAGES  2     input synchroniser depth, 2..4
// PORTS
//  clk            in   1      system clock
//  reset          in   1      asynchronous, active-high reset
//  avs_address    in   3      register word offset
//  avs_read       in   1      read strobe
//  avs_write      in   1      write strobe
//  avs_writedata  in   32     write data
//  avs_readdata   out  32     read data, registered, fixed read latency 1
//  pio_in         in   WIDTH  asynchronous pin inputs
//  pio_out        out  WIDTH  output data register
//  pio_oe         out  WIDTH  per-bit output enable (1 = drive)
//  irq            out  1      level interrupt, registered
// BEHAVIOUR
//  One clock (clk); reset asynchronous active-high, all state below cleared on assertion.
//  Reset values: pio_out=RESET_VALUE, pio_oe=0, mask=0, edge=0, irq=0, avs_readdata=0, sync chain=0.
//  No waitrequest; writes take effect at the clock edge they are sampled; readdata valid 1 cycle
//  after avs_read, held until next read. read and write in same cycle: both performed, read
//  returns pre-write value.
//  Register map (offset: R/W):
//   0 DATA   R: bit i = pio_oe[i] ? pio_out[i] : sync_in[i]; W: pio_out <= wdata (all bits)
//   1 DIR    R/W pio_oe
//   2 MASK   R/W interrupt mask
//   3 EDGE   R captured edges; W: write-1-to-clear per bit
//   4 OUTSET W: pio_out <= pio_out | wdata   (see CONFIGURATION); R: 0
//   5 OUTCLR W: pio_out <= pio_out & ~wdata  (see CONFIGURATION); R: 0
//   6,7      reserved: read 0, writes ignored
//  Input path: pio_in through SYNC_STAGES flops -> sync_in; prev register holds last sync_in.
//  Edge detect per bit, only when pio_oe[i]=0: rising = sync&~prev, falling = ~sync&prev.
//  Arming FSM: ARMING (counter 0..SYNC_STAGES) -> ARMED; edge detection disabled while ARMING so
//  pins high at reset do not raise spurious edges. Counter starts on first clock after reset
//  deasserts; ARMED reached SYNC_STAGES+1 cycles later; only reset returns to ARMING.
//  EDGE bit sets on detected edge, sticky until W1C; same-cycle detect and W1C of same bit: set wins.
//  irq <= |(edge & mask), registered: asserts 1 cycle after the edge bit sets / mask written;
//  deasserts 1 cycle after clear. Latency pin->edge bit: SYNC_STAGES+1 cycles.
//  Direction change output->input: prev is updated every cycle regardless of pio_oe, so no
//  stale edge is generated from history while the bit was an output.
//  Reset mid-transaction: pending read discarded, readdata 0, FSM to ARMING.
// CONFIGURATION
//  PIO_BIT_SETCLR_EN defined: offsets 4/5 perform atomic set/clear as above; simultaneous writes are
//   impossible (single port). Not defined: offsets 4/5 reserved (read 0, writes ignored), set/clear
//   logic absent.
// TESTING
//  1 Reset, WIDTH=8, RESET_VALUE=8'hA5 -> pio_out=A5, pio_oe=0, irq=0; read DATA w/ pio_in=3C -> 0000003C.
//  2 Write DIR=0F, DATA=FF, pio_in=A0 -> pio_out=FF; read DATA -> 000000AF one cycle after avs_read.
//  3 pio_in held 01 through reset -> after arming, EDGE reads 0, irq stays 0 (no spurious edge).
//  4 MASK=01, EDGE_TYPE=0, pio_in bit0 0->1 -> EDGE=01 after 3 cycles, irq=1 next cycle;
//    write EDGE=01 -> irq=0 one cycle later; W1C in same cycle as new edge -> EDGE stays 01.
//  5 PIO_BIT_SETCLR_EN, pio_out=F0: write OUTSET=05 -> F5; OUTCLR=30 -> C5; without macro -> stays F0.
//  6 Read offset 6 -> 0; WIDTH=32 DATA write FFFFFFFF -> readback FFFFFFFF with DIR=FFFFFFFF.

Source files
------------

// File: rtl/avalon_pio_gen.sv
// Avalon-MM general-purpose I/O: per-bit direction, input synchroniser, edge capture, masked irq.
// Optional atomic set/clear of output bits at offsets 4/5 when PIO_BIT_SETCLR_EN is defined.
module avalon_pio_gen #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               EDGE_TYPE   = 0,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  input  logic [WIDTH-1:0] pio_in,
  output logic [WIDTH-1:0] pio_out,
  output logic [WIDTH-1:0] pio_oe,
  output logic             irq
);

  typedef enum logic {ST_ARMING, ST_ARMED} state_t;

  state_t                            state, state_nxt;
  logic [2:0]                        arm_cnt, arm_cnt_nxt;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_p;
  logic [WIDTH-1:0]                  sync_in, prev_in;
  logic [WIDTH-1:0]                  mask, edge_cap, detect;
  logic [WIDTH-1:0]                  wdata_w, out_nxt, rd_val, w1c;
  logic [31:0]                       rd_word;
  logic                              wr_data, wr_dir, wr_mask, wr_edge;
  logic                              unused_wdata;

  function automatic logic [WIDTH-1:0] edge_select(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] prv);
    case (EDGE_TYPE)
      0:       return cur & ~prv;
      1:       return ~cur & prv;
      default: return cur ^ prv;
    endcase
  endfunction

  assign wdata_w      = avs_writedata[WIDTH-1:0];
  assign unused_wdata = ^avs_writedata;
  assign sync_in      = sync_p[SYNC_STAGES-1];

  assign wr_data = avs_write && (avs_address == 3'd0);
  assign wr_dir  = avs_write && (avs_address == 3'd1);
  assign wr_mask = avs_write && (avs_address == 3'd2);
  assign wr_edge = avs_write && (avs_address == 3'd3);
  assign w1c     = wr_edge ? wdata_w : '0;

  // Edges are ignored while arming so pins already high at reset are not captured.
  assign detect = (state == ST_ARMED) ? (edge_select(sync_in, prev_in) & ~pio_oe) : '0;

  always_comb begin
    state_nxt   = state;
    arm_cnt_nxt = arm_cnt;
    case (state)
      ST_ARMING: begin
        if (arm_cnt == 3'(SYNC_STAGES)) state_nxt = ST_ARMED;
        else                            arm_cnt_nxt = arm_cnt + 3'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    out_nxt = pio_out;
    if (wr_data) out_nxt = wdata_w;
`ifdef PIO_BIT_SETCLR_EN
    if (avs_write && (avs_address == 3'd4)) out_nxt = pio_out | wdata_w;
    if (avs_write && (avs_address == 3'd5)) out_nxt = pio_out & ~wdata_w;
`endif
  end

  always_comb begin
    rd_val = '0;
    case (avs_address)
      3'd0:    rd_val = (pio_oe & pio_out) | (~pio_oe & sync_in);
      3'd1:    rd_val = pio_oe;
      3'd2:    rd_val = mask;
      3'd3:    rd_val = edge_cap;
      default: rd_val = '0;
    endcase
    rd_word              = '0;
    rd_word[WIDTH-1:0]   = rd_val;
  end

  // Stage p0: synchroniser, registers, readdata and irq all update on the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_ARMING;
      arm_cnt      <= '0;
      sync_p       <= '0;
      prev_in      <= '0;
      pio_out      <= RESET_VALUE;
      pio_oe       <= '0;
      mask         <= '0;
      edge_cap     <= '0;
      irq          <= 1'b0;
      avs_readdata <= '0;
    end else begin
      state    <= state_nxt;
      arm_cnt  <= arm_cnt_nxt;
      sync_p   <= {sync_p[SYNC_STAGES-2:0], pio_in};
      prev_in  <= sync_in;
      pio_out  <= out_nxt;
      if (wr_dir)  pio_oe <= wdata_w;
      if (wr_mask) mask   <= wdata_w;
      edge_cap <= (edge_cap & ~w1c) | detect;
      irq      <= |(edge_cap & mask);
      if (avs_read) avs_readdata <= rd_word;
    end
  end

endmodule

// File: tb/tb_avalon_pio_gen.sv
// Self-checking bench for avalon_pio_gen: directed steps plus random traffic against a
// pin-history reference model.
module tb_avalon_pio_gen;
  localparam int             W  = 8;
  localparam int             S  = 2;
  localparam int             ET = 0;
  localparam logic [W-1:0]   RV = 8'hA5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    avs_address = '0;
  logic          avs_read = 1'b0, avs_write = 1'b0;
  logic [31:0]   avs_writedata = '0, avs_readdata;
  logic [W-1:0]  pio_in = '0, pio_out, pio_oe;
  logic          irq;

  logic [2:0]    b_address = '0;
  logic          b_read = 1'b0, b_write = 1'b0;
  logic [31:0]   b_writedata = '0, b_readdata, b_in = '0, b_out, b_oe;
  logic          b_irq;

  avalon_pio_gen #(.WIDTH(W), .RESET_VALUE(RV), .EDGE_TYPE(ET), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .pio_in(pio_in), .pio_out(pio_out), .pio_oe(pio_oe), .irq(irq));

  avalon_pio_gen #(.WIDTH(32), .RESET_VALUE(32'h0), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut32 (
    .clk(clk), .reset(reset), .avs_address(b_address), .avs_read(b_read),
    .avs_write(b_write), .avs_writedata(b_writedata), .avs_readdata(b_readdata),
    .pio_in(b_in), .pio_out(b_out), .pio_oe(b_oe), .irq(b_irq));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] m_out, m_oe, m_mask, m_edge;
  logic         m_irq;
  logic [31:0]  m_rd;
  int           m_n;
  logic [W-1:0] pins[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pin value sampled at the k-th clock after reset release (0 before that).
  function automatic logic [W-1:0] pin_at(input int k);
    if (k < 1 || k > pins.size()) return '0;
    return pins[k-1];
  endfunction

  function automatic logic [W-1:0] edges(input logic [W-1:0] s, input logic [W-1:0] p);
    case (ET)
      0:       return s & ~p;
      1:       return ~s & p;
      default: return s ^ p;
    endcase
  endfunction

  task automatic model_reset();
    m_out = RV; m_oe = '0; m_mask = '0; m_edge = '0; m_irq = 1'b0; m_rd = '0; m_n = 0;
    pins.delete();
  endtask

  // Called at a falling edge; returns at a falling edge with reset released.
  task automatic do_reset(input logic [W-1:0] pin, input logic pend_rd);
    avs_read = pend_rd; avs_write = 1'b0; avs_address = 3'd0; pio_in = pin;
    #1 reset = 1'b1;
    model_reset();
    #1;
    check("rst_pio_out", pio_out, RV);
    check("rst_pio_oe", pio_oe, 0);
    check("rst_irq", irq, 0);
    check("rst_readdata", avs_readdata, 0);
    check("rst_readdata32", b_readdata, 0);
    avs_read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One bus cycle: drive at the falling edge, update the model at the rising edge, check 1 after.
  task automatic step(input logic rd, input logic wr, input logic [2:0] a,
                      input logic [31:0] wd, input logic [W-1:0] pin);
    logic [W-1:0] sync_now, prev_now, det, wd_w;
    logic [31:0]  rdv;
    avs_read = rd; avs_write = wr; avs_address = a; avs_writedata = wd; pio_in = pin;
    @(posedge clk);
    m_n++;
    pins.push_back(pin);
    sync_now = pin_at(m_n - S);
    prev_now = pin_at(m_n - S - 1);
    wd_w = wd[W-1:0];
    if (rd) begin
      rdv = '0;
      case (a)
        3'd0:    rdv[W-1:0] = (m_oe & m_out) | (~m_oe & sync_now);
        3'd1:    rdv[W-1:0] = m_oe;
        3'd2:    rdv[W-1:0] = m_mask;
        3'd3:    rdv[W-1:0] = m_edge;
        default: rdv = '0;
      endcase
      m_rd = rdv;
    end
    det = (m_n >= S + 2) ? (edges(sync_now, prev_now) & ~m_oe) : '0;
    m_irq = |(m_edge & m_mask);
    if (wr) begin
      case (a)
        3'd0: m_out = wd_w;
        3'd1: m_oe = wd_w;
        3'd2: m_mask = wd_w;
        3'd3: m_edge = m_edge & ~wd_w;
`ifdef PIO_BIT_SETCLR_EN
        3'd4: m_out = m_out | wd_w;
        3'd5: m_out = m_out & ~wd_w;
`endif
        default: ;
      endcase
    end
    m_edge = m_edge | det;
    #1;
    check("pio_out", pio_out, m_out);
    check("pio_oe", pio_oe, m_oe);
    check("irq", irq, m_irq);
    check("readdata", avs_readdata, m_rd);
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] pin;
    model_reset();
    @(negedge clk);

    do_reset(8'h3C, 1'b0);
    repeat (4) step(0, 0, 3'd0, 0, 8'h3C);
    step(1, 0, 3'd0, 0, 8'h3C);
    check("t1_data", avs_readdata, 32'h0000003C);

    step(0, 1, 3'd1, 32'h0F, 8'hA0);
    step(0, 1, 3'd0, 32'hFF, 8'hA0);
    check("t2_pio_out", pio_out, 32'hFF);
    step(0, 0, 3'd0, 0, 8'hA0);
    step(1, 0, 3'd0, 0, 8'hA0);
    check("t2_data", avs_readdata, 32'h000000AF);

    do_reset(8'h01, 1'b1);
    repeat (6) step(0, 0, 3'd0, 0, 8'h01);
    step(1, 0, 3'd3, 0, 8'h01);
    check("t3_edge", avs_readdata, 32'h0);
    check("t3_irq", irq, 0);

    step(0, 1, 3'd2, 32'h01, 8'h01);
    repeat (4) step(0, 0, 3'd0, 0, 8'h00);
    step(0, 0, 3'd0, 0, 8'h01);
    step(0, 0, 3'd0, 0, 8'h01);
    step(0, 0, 3'd0, 0, 8'h01);
    step(1, 0, 3'd3, 0, 8'h01);
    check("t4_edge", avs_readdata, 32'h01);
    check("t4_irq_set", irq, 1);
    step(0, 1, 3'd3, 32'h01, 8'h01);
    step(0, 0, 3'd0, 0, 8'h01);
    check("t4_irq_clr", irq, 0);
    repeat (3) step(0, 0, 3'd0, 0, 8'h00);
    step(0, 0, 3'd0, 0, 8'h01);
    step(0, 0, 3'd0, 0, 8'h01);
    step(0, 1, 3'd3, 32'h01, 8'h01);
    step(1, 0, 3'd3, 0, 8'h01);
    check("t4_set_wins", avs_readdata, 32'h01);

    step(0, 1, 3'd1, 32'hFF, 8'h00);
    step(0, 1, 3'd0, 32'hF0, 8'h00);
    step(0, 1, 3'd4, 32'h05, 8'h00);
`ifdef PIO_BIT_SETCLR_EN
    check("t5_outset", pio_out, 32'hF5);
`else
    check("t5_outset", pio_out, 32'hF0);
`endif
    step(0, 1, 3'd5, 32'h30, 8'h00);
`ifdef PIO_BIT_SETCLR_EN
    check("t5_outclr", pio_out, 32'hC5);
`else
    check("t5_outclr", pio_out, 32'hF0);
`endif

    step(1, 0, 3'd6, 0, 8'h00);
    check("t6_reserved", avs_readdata, 32'h0);
    step(1, 1, 3'd4, 32'hFF, 8'h00);
    check("t6_outset_read", avs_readdata, 32'h0);

    b_write = 1'b1; b_address = 3'd1; b_writedata = 32'hFFFFFFFF;
    step(0, 0, 3'd0, 0, 8'h00);
    b_address = 3'd0;
    step(0, 0, 3'd0, 0, 8'h00);
    b_write = 1'b0; b_read = 1'b1;
    step(0, 0, 3'd0, 0, 8'h00);
    b_read = 1'b0;
    check("t6_w32_data", b_readdata, 32'hFFFFFFFF);
    check("t6_w32_oe", b_oe, 32'hFFFFFFFF);
    check("t6_w32_irq", b_irq, 0);

    pin = 8'h00;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset(pin, 1'b1);
      if ($urandom_range(0, 3) == 0) pin = W'($urandom);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           $urandom, pin);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
